// File: rtl/act_buf_pkg.sv
// Shared types and width helpers for the sparse activation row buffer.
package act_buf_pkg;

  // Replay mode as seen on the mode input and latched on rd_start acceptance.
  typedef enum logic {
    MODE_SERIAL   = 1'b0,
    MODE_PARALLEL = 1'b1
  } act_mode_e;

  // Replay FSM states.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    SER,
    PAR,
    DONE
  } buf_state_e;

  // Index width for n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must represent 0..n inclusive when n is a power of two.
  function automatic int count_width(input int n);
    return idx_width(n) + 1;
  endfunction

endpackage

// File: rtl/lsb_index_enc.sv
// Find-first-set from the LSB: index of the lowest set bit, an any-set flag,
// and the mask with that lowest bit cleared.
module lsb_index_enc
  import act_buf_pkg::*;
#(
  parameter int NUM_COL   = 16,
  parameter int IDX_WIDTH = idx_width(NUM_COL)
) (
  input  logic [NUM_COL-1:0]   mask,
  output logic [IDX_WIDTH-1:0] index,
  output logic                 any_set,
  output logic [NUM_COL-1:0]   rest
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    index = '0;
    for (int i = NUM_COL - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = IDX_WIDTH'(i);
      end
    end
  end

  assign any_set = |mask;
  assign rest    = mask & (mask - NUM_COL'(1));

endmodule

// File: rtl/act_buffer_sparse.sv
// Sparse activation row buffer: stores rows with nonzero flags in a RAM and
// replays the oldest row either one nonzero element per beat or whole-row.
module act_buffer_sparse
  import act_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_COL    = 16,
  parameter int DEPTH      = 32,
  parameter int IDX_WIDTH  = idx_width(NUM_COL),
  parameter int ADDR_WIDTH = idx_width(DEPTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             mode,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [NUM_COL-1:0]               wr_flag,
  input  logic [NUM_COL*DATA_WIDTH-1:0]    wr_data,
  input  logic                             rd_start,
  output logic                             rd_busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [IDX_WIDTH-1:0]             out_index,
  output logic [DATA_WIDTH-1:0]            out_serial,
  output logic [NUM_COL*DATA_WIDTH-1:0]    out_parallel,
  output logic [NUM_COL-1:0]               out_flag,
  output logic [IDX_WIDTH:0]               row_nnz,
  output logic                             row_done,
  output logic [ADDR_WIDTH:0]              count,
  output logic                             empty,
  output logic                             full
);

  localparam int ROW_W  = NUM_COL * DATA_WIDTH;
  localparam int WORD_W = ROW_W + NUM_COL;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [WORD_W-1:0]     rd_word;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  buf_state_e            state;
  act_mode_e             mode_q;
  logic [ROW_W-1:0]      row_q;
  logic [NUM_COL-1:0]    mask_q;
  logic [NUM_COL-1:0]    flag_q;
  logic [IDX_WIDTH:0]    nnz_q;

  logic [NUM_COL-1:0]    fetch_flag;
  logic [ROW_W-1:0]      fetch_row;
  logic [IDX_WIDTH:0]    fetch_nnz;

  logic [IDX_WIDTH-1:0]  enc_index;
  logic                  enc_any;
  logic [NUM_COL-1:0]    enc_rest;

  logic                  wr_fire;
  logic                  retire;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign wr_ready = !full;
  assign wr_fire  = wr_valid && wr_ready;
  assign retire   = (state == DONE);

  // Row RAM write port; flag is stored above the data in the same word.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= {wr_flag, wr_data};
    end
  end

  // Synchronous RAM read issued in LOAD, data visible during FETCH.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      rd_word <= mem[rd_ptr];
    end
  end

  assign fetch_flag = rd_word[ROW_W +: NUM_COL];

  // Zero the lanes whose flag is clear and count the set flags of the fetched row.
  always_comb begin
    fetch_row = '0;
    fetch_nnz = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      if (fetch_flag[c]) begin
        fetch_row[c*DATA_WIDTH +: DATA_WIDTH] = rd_word[c*DATA_WIDTH +: DATA_WIDTH];
        fetch_nnz = fetch_nnz + (IDX_WIDTH + 1)'(1);
      end
    end
  end

  lsb_index_enc #(
    .NUM_COL   (NUM_COL),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_enc (
    .mask    (mask_q),
    .index   (enc_index),
    .any_set (enc_any),
    .rest    (enc_rest)
  );

  // Write pointer and occupancy; a write and a retire in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (wr_fire && !retire) begin
        count <= count + (ADDR_WIDTH + 1)'(1);
      end else if (!wr_fire && retire) begin
        count <= count - (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  // Replay FSM with its registered handshake outputs and the held row registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mode_q    <= MODE_SERIAL;
      rd_ptr    <= '0;
      row_q     <= '0;
      mask_q    <= '0;
      flag_q    <= '0;
      nnz_q     <= '0;
      out_valid <= 1'b0;
      row_done  <= 1'b0;
      rd_busy   <= 1'b0;
    end else begin
      row_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_start && !empty) begin
            state   <= LOAD;
            mode_q  <= act_mode_e'(mode);
            rd_busy <= 1'b1;
          end
        end
        LOAD: begin
          state <= FETCH;
        end
        FETCH: begin
          row_q  <= fetch_row;
          mask_q <= fetch_flag;
          flag_q <= fetch_flag;
          nnz_q  <= fetch_nnz;
          if (mode_q == MODE_PARALLEL) begin
            state     <= PAR;
            out_valid <= 1'b1;
          end else if (fetch_flag == '0) begin
            state    <= DONE;
            row_done <= 1'b1;
          end else begin
            state     <= SER;
            out_valid <= 1'b1;
          end
        end
        SER: begin
          if (out_ready) begin
            mask_q <= enc_rest;
            if (enc_rest == '0) begin
              state     <= DONE;
              out_valid <= 1'b0;
              row_done  <= 1'b1;
            end
          end
        end
        PAR: begin
          if (out_ready) begin
            state     <= DONE;
            out_valid <= 1'b0;
            row_done  <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          rd_busy <= 1'b0;
          rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
          mask_q  <= '0;
          flag_q  <= '0;
          nnz_q   <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign out_index    = (state == SER) ? enc_index : '0;
  assign out_parallel = (state == PAR) ? row_q : '0;
  assign out_flag     = flag_q;
  assign row_nnz      = nnz_q;

  // Select the serial element for the current lowest remaining column.
  always_comb begin
    out_serial = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      if (state == SER && enc_any && enc_index == IDX_WIDTH'(c)) begin
        out_serial = row_q[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_act_buffer_sparse.sv
// Self-checking bench for act_buffer_sparse against a queue-based row model.
module tb_act_buffer_sparse;

  localparam int DW    = 8;
  localparam int NC    = 16;
  localparam int DEPTH = 32;
  localparam int IW    = 4;
  localparam int AW    = 5;
  localparam int RW    = NC * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic          wr_valid;
  logic          wr_ready;
  logic [NC-1:0] wr_flag;
  logic [RW-1:0] wr_data;
  logic          rd_start;
  logic          rd_busy;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic [DW-1:0] out_serial;
  logic [RW-1:0] out_parallel;
  logic [NC-1:0] out_flag;
  logic [IW:0]   row_nnz;
  logic          row_done;
  logic [AW:0]   count;
  logic          empty;
  logic          full;

  int tests    = 0;
  int failures = 0;

  bit [NC-1:0] mflag[$];
  bit [RW-1:0] mdata[$];

  always #5 clk = ~clk;

  act_buffer_sparse #(
    .DATA_WIDTH (DW),
    .NUM_COL    (NC),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mode         (mode),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_flag      (wr_flag),
    .wr_data      (wr_data),
    .rd_start     (rd_start),
    .rd_busy      (rd_busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_serial   (out_serial),
    .out_parallel (out_parallel),
    .out_flag     (out_flag),
    .row_nnz      (row_nnz),
    .row_done     (row_done),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  task automatic checkOutput(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive all inputs at a falling edge and advance to the next falling edge.
  task automatic applyStimulus(input logic wv, input logic [NC-1:0] wf, input logic [RW-1:0] wd,
                               input logic rs, input logic md, input logic ordy);
    wr_valid  = wv;
    wr_flag   = wf;
    wr_data   = wd;
    rd_start  = rs;
    mode      = md;
    out_ready = ordy;
    @(negedge clk);
  endtask

  function automatic logic [RW-1:0] randRow();
    logic [RW-1:0] r;
    for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [RW-1:0] parExp(input logic [NC-1:0] f, input logic [RW-1:0] d);
    logic [RW-1:0] e;
    e = '0;
    for (int c = 0; c < NC; c++) if (f[c]) e[c*DW +: DW] = d[c*DW +: DW];
    return e;
  endfunction

  task automatic writeRow(input logic [NC-1:0] f, input logic [RW-1:0] d);
    bit accept;
    accept = (mflag.size() < DEPTH);
    checkOutput("wr_ready", wr_ready, accept);
    applyStimulus(1'b1, f, d, 1'b0, 1'b0, 1'b0);
    wr_valid = 1'b0;
    if (accept) begin
      mflag.push_back(f);
      mdata.push_back(d);
    end
    checkOutput("count_after_write", count, mflag.size());
  endtask

  // Replay the oldest model row and compare every beat with the model.
  task automatic replayRow(input logic md, input bit use_rand, input logic [7:0] pat);
    bit [NC-1:0] f;
    bit [RW-1:0] d;
    int cols[$];
    int beat;
    int k;
    bit done;
    bit zero;
    logic ordy;
    f = mflag[0];
    d = mdata[0];
    for (int c = 0; c < NC; c++) if (f[c]) cols.push_back(c);
    zero = (md == 1'b0) && (f == '0);
    checkOutput("rd_busy_idle", rd_busy, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, md, 1'b0);
    rd_start = 1'b0;
    checkOutput("rd_busy_load", rd_busy, 1'b1);
    checkOutput("valid_load", out_valid, 1'b0);
    @(negedge clk);
    checkOutput("valid_fetch", out_valid, 1'b0);
    @(negedge clk);
    checkOutput("first_valid_t3", out_valid, !zero);
    checkOutput("row_done_t3", row_done, zero);
    checkOutput("row_nnz", row_nnz, $countones(f));
    checkOutput("out_flag", out_flag, f);
    beat = 0;
    k    = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (row_done) begin
        checkOutput("beats_consumed", beat, md ? 1 : cols.size());
        checkOutput("valid_at_done", out_valid, 1'b0);
        checkOutput("flag_hold_done", out_flag, f);
        done = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
      end else begin
        checkOutput("out_valid", out_valid, 1'b1);
        checkOutput("nnz_hold", row_nnz, $countones(f));
        if (md) begin
          checkOutput("out_parallel", out_parallel, parExp(f, d));
        end else if (beat < cols.size()) begin
          checkOutput("out_index", out_index, cols[beat]);
          checkOutput("out_serial", out_serial, d[cols[beat]*DW +: DW]);
        end else begin
          checkOutput("row_done_missing", row_done, 1'b1);
        end
        ordy = use_rand ? 1'($urandom_range(0, 1)) : pat[k%8];
        k++;
        out_ready = ordy;
        mode      = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (ordy) beat++;
      end
    end
    if (!done) checkOutput("replay_timeout", row_done, 1'b1);
    void'(mflag.pop_front());
    void'(mdata.pop_front());
    checkOutput("row_done_pulse", row_done, 1'b0);
    checkOutput("rd_busy_after", rd_busy, 1'b0);
    checkOutput("flag_idle", out_flag, '0);
    checkOutput("nnz_idle", row_nnz, '0);
    checkOutput("count_after_retire", count, mflag.size());
  endtask

  initial begin
    logic [RW-1:0] d;
    reset = 1'b1;
    wr_valid = 1'b0; wr_flag = '0; wr_data = '0;
    rd_start = 1'b0; mode = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_wr_ready", wr_ready, 1'b1);
    checkOutput("rst_empty", empty, 1'b1);
    checkOutput("rst_full", full, 1'b0);
    checkOutput("rst_count", count, '0);
    checkOutput("rst_rd_busy", rd_busy, 1'b0);
    checkOutput("rst_row_done", row_done, 1'b0);
    checkOutput("rst_out_parallel", out_parallel, '0);

    // Known row: lanes 0, 5, 10, 15 with data c+1, serial then parallel.
    for (int c = 0; c < NC; c++) d[c*DW +: DW] = DW'(c + 1);
    writeRow(16'h8421, d);
    replayRow(1'b0, 1'b0, 8'hFF);
    writeRow(16'h8421, d);
    replayRow(1'b1, 1'b0, 8'hFF);

    // Stall pattern 1,0,0,1 on a serial row.
    writeRow(16'h0F0F, randRow());
    replayRow(1'b0, 1'b0, 8'b1001_1001);

    // Empty replay request is ignored.
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    rd_start = 1'b0;
    checkOutput("rd_start_empty", rd_busy, 1'b0);

    // Zero-flag serial row retiring in the same cycle as a new write.
    writeRow('0, randRow());
    writeRow(16'h00F0, randRow());
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    rd_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("zero_row_done_t3", row_done, 1'b1);
    checkOutput("zero_row_no_valid", out_valid, 1'b0);
    d = randRow();
    applyStimulus(1'b1, 16'h1234, d, 1'b0, 1'b0, 1'b0);
    wr_valid = 1'b0;
    void'(mflag.pop_front());
    void'(mdata.pop_front());
    mflag.push_back(16'h1234);
    mdata.push_back(d);
    checkOutput("count_wr_and_retire", count, 2);
    checkOutput("zero_row_pulse", row_done, 1'b0);
    replayRow(1'b0, 1'b1, 8'h00);
    replayRow(1'b1, 1'b1, 8'h00);

    // Fill to capacity, drop one extra write, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      writeRow(($urandom_range(0, 3) == 0) ? NC'(0) : NC'($urandom), randRow());
    checkOutput("full_flag", full, 1'b1);
    checkOutput("full_wr_ready", wr_ready, 1'b0);
    checkOutput("full_count", count, DEPTH);
    writeRow(16'hFFFF, randRow());
    for (int i = 0; i < DEPTH; i++) replayRow(1'($urandom_range(0, 1)), 1'b1, 8'h00);
    checkOutput("drained_empty", empty, 1'b1);

    // Reset in the middle of a serial row.
    writeRow(16'hFFFF, randRow());
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    rd_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("ser_before_reset", out_valid, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mflag.delete();
    mdata.delete();
    checkOutput("mid_rst_valid", out_valid, 1'b0);
    checkOutput("mid_rst_count", count, '0);
    checkOutput("mid_rst_empty", empty, 1'b1);
    checkOutput("mid_rst_busy", rd_busy, 1'b0);
    checkOutput("mid_rst_flag", out_flag, '0);
    writeRow(16'hA005, randRow());
    replayRow(1'b0, 1'b1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/act_buffer_sparse.md
Name: act_buffer_sparse

Overview:
- Parametrised sparse activation row buffer, next generation of the PE-array activation store.
- Holds up to DEPTH rows of NUM_COL activations, each row with a NUM_COL-bit nonzero flag.
- Replays rows in one of two modes:
  - serial: one nonzero element per beat, lowest column first, with its column index;
  - parallel: the whole row in one beat.
- Adds valid/ready flow control on both sides, full/empty status and per-row nonzero count.

Parameters:
- DATA_WIDTH, 8, bits per activation.
- NUM_COL, 16, activations per row (lanes).
- DEPTH, 32, row capacity (power of two).
- IDX_WIDTH, $clog2(NUM_COL), column index width.
- ADDR_WIDTH, $clog2(DEPTH), row pointer width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- mode  in  1  0=serial, 1=parallel; sampled on rd_start acceptance.
- wr_valid  in  1  write row offered.
- wr_ready  out  1  buffer can accept a row (!full).
- wr_flag  in  NUM_COL  nonzero flag per column.
- wr_data  in  NUM_COL*DATA_WIDTH  row data; column c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- rd_start  in  1  request replay of the oldest row.
- rd_busy  out  1  FSM not in IDLE.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- out_index  out  IDX_WIDTH  column of the serial element.
- out_serial  out  DATA_WIDTH  serial element.
- out_parallel  out  NUM_COL*DATA_WIDTH  full row; masked to zero where flag=0.
- out_flag  out  NUM_COL  flag of the current row.
- row_nnz  out  IDX_WIDTH+1  popcount of the current row's flag.
- row_done  out  1  one-cycle pulse when the row is retired.
- count  out  ADDR_WIDTH+1  rows stored.
- empty, full  out  1  status.

Behaviour:
- Reset (synchronous, active-high, any cycle including mid-row): pointers and count go to 0; FSM goes to IDLE; all outputs go to 0 except wr_ready=1 and empty=1; stored data is don't-care.
- Write: a row is stored when wr_valid&&wr_ready. It is written at wr_ptr, and wr_ptr wraps modulo DEPTH.
- Storage: row RAM has synchronous read, 1-cycle latency.
- FSM IDLE:
  - rd_start&&!empty moves to LOAD and latches mode.
  - rd_start while empty is ignored.
- FSM LOAD: issue read at rd_ptr; next state is FETCH.
- FSM FETCH:
  - Register RAM data into the row register and flag into the mask register; compute row_nnz.
  - Go to SER if mode=0, else PAR.
  - If mode=0 and flag=0, go straight to DONE.
- FSM SER:
  - out_valid=1; out_index = lowest set bit of the mask; out_serial = row[out_index].
  - On out_ready, clear that bit.
  - When the last set bit is accepted, go to DONE.
- FSM PAR: out_valid=1 for one beat; hold until out_ready, then go to DONE.
- FSM DONE:
  - row_done=1 for one cycle; rd_ptr increments (wraps); count decrements; go to IDLE.
  - A zero-flag row retires with no out_valid beat.
- Latency: rd_start accepted at cycle T gives first out_valid at T+3. Serial throughput is 1 element/cycle under continuous out_ready.
- Stall: while out_valid&&!out_ready, out_index, out_serial and out_parallel are stable.
- Output hold: out_flag and row_nnz are held from FETCH through DONE; they are 0 in IDLE.
- Simultaneous write and DONE retire: count is unchanged.
- Full: wr_ready=0; wr_valid is ignored and count never exceeds DEPTH.
- Write-while-reading: a write never corrupts the row being replayed, because the row is held in registers after FETCH.
- Mode change mid-row: ignored until the next rd_start.

Decomposition:
- Package act_buf_pkg:
  - mode encoding (MODE_SERIAL=0, MODE_PARALLEL=1);
  - FSM state typedef (IDLE, LOAD, FETCH, SER, PAR, DONE);
  - width helper functions.
- Sub-module lsb_index_enc: parametrised NUM_COL find-first-set from LSB. Outputs the index, an any-set flag, and the mask with that bit cleared.

Test Plan:
- Write flag=16'h8421, data[c]=c+1, mode=0, out_ready=1 -> 4 beats: index/value 0/1, 5/6, 10/11, 15/16; row_nnz=4; row_done one cycle after the last beat.
- Same row with mode=1 -> single beat; out_parallel nonzero only in lanes 0, 5, 10, 15; out_flag=16'h8421.
- Write DEPTH rows -> full=1, wr_ready=0, count=DEPTH. A further write is dropped; replaying all rows returns them in order and pointers wrap.
- flag=0, mode=0 -> no out_valid; row_done pulses at T+3; count decrements.
- Serial row with out_ready toggling 1,0,0,1 -> index/data held stable while stalled; no element lost or duplicated.
- Assert reset in SER mid-row -> next cycle out_valid=0, count=0, empty=1, rd_busy=0; a subsequent write+read works normally.
